wb_commit_unit: RTL and testbench

- Parametrised successor to the single-cycle write-back stage.
- Sits at the MEM→WB boundary. Commits one instruction per accept, writes rd, and raises trap requests for exceptions and synchronised interrupts.
- Stalls the pipeline while a selected long-latency unit (divider, iterative multiplier, …) has not yet produced its result.
- CSR state is not held here. The trap controller consumes `wb_trap`, `wb_trap_cause` and `wb_trap_epc`.

---
 rtl/wb_commit_unit_pkg.sv | 19 +
 rtl/wb_commit_unit_if.sv | 35 +++
 rtl/wb_commit_unit_irq_sync.sv | 23 ++
 rtl/wb_commit_unit.sv | 179 +++++++++++++++++
 tb/tb_wb_commit_unit.sv | 277 +++++++++++++++++++++++++++
 5 files changed

// File: rtl/wb_commit_unit_pkg.sv
// Shared definitions for the write-back commit unit: FSM states, interrupt causes
// and the mcause interrupt-bit position helper.
package wb_commit_unit_pkg;

  typedef enum logic [1:0] {
    WB_IDLE    = 2'd0,
    WB_WAIT_MC = 2'd1,
    WB_TRAP    = 2'd2
  } wb_state_e;

  localparam logic [3:0] IRQ_MEI = 4'd11;
  localparam logic [3:0] IRQ_MSI = 4'd3;
  localparam logic [3:0] IRQ_MTI = 4'd7;

  function automatic int unsigned mcause_irq_bit(input int unsigned xlen);
    return xlen - 1;
  endfunction

endpackage

// File: rtl/wb_commit_unit_if.sv
// MEM->WB handshake and multi-cycle result channels seen by the commit unit.
interface wb_commit_unit_if #(
  parameter int unsigned XLEN   = 32,
  parameter int unsigned REG_AW = 5,
  parameter int unsigned NUM_MC = 2
);
  logic                   wb_pipe_valid;
  logic                   wb_pipe_ready;
  logic                   wb_pipe_flush;
  logic [XLEN-1:0]        wb_pipe_pc;
  logic                   wb_pipe_rd_write;
  logic [REG_AW-1:0]      wb_pipe_rd_addr;
  logic [XLEN-1:0]        wb_pipe_rd_data;
  logic [NUM_MC-1:0]      wb_pipe_mc_sel;
  logic                   wb_pipe_exc_pending;
  logic [3:0]             wb_pipe_exc_code;
  logic                   wb_pipe_mret;
  logic [NUM_MC-1:0]      mc_result_valid;
  logic [NUM_MC*XLEN-1:0] mc_result;
  logic [NUM_MC-1:0]      mc_result_ack;

  modport master (
    output wb_pipe_valid, wb_pipe_pc, wb_pipe_rd_write, wb_pipe_rd_addr, wb_pipe_rd_data,
           wb_pipe_mc_sel, wb_pipe_exc_pending, wb_pipe_exc_code, wb_pipe_mret,
           mc_result_valid, mc_result,
    input  wb_pipe_ready, wb_pipe_flush, mc_result_ack
  );

  modport slave (
    input  wb_pipe_valid, wb_pipe_pc, wb_pipe_rd_write, wb_pipe_rd_addr, wb_pipe_rd_data,
           wb_pipe_mc_sel, wb_pipe_exc_pending, wb_pipe_exc_code, wb_pipe_mret,
           mc_result_valid, mc_result,
    output wb_pipe_ready, wb_pipe_flush, mc_result_ack
  );
endinterface

// File: rtl/wb_commit_unit_irq_sync.sv
// Per-bit DEPTH-stage synchroniser for asynchronous interrupt lines.
module irq_sync #(
  parameter int unsigned WIDTH = 3,
  parameter int unsigned DEPTH = 2
) (
  input  logic             clk,
  input  logic             rst_b,
  input  logic [WIDTH-1:0] irq_i,
  output logic [WIDTH-1:0] irq_o
);
  logic [WIDTH-1:0] stage_q [DEPTH];

  always_ff @(posedge clk or negedge rst_b) begin
    if (!rst_b) begin
      for (int unsigned i = 0; i < DEPTH; i++) stage_q[i] <= '0;
    end else begin
      stage_q[0] <= irq_i;
      for (int unsigned i = 1; i < DEPTH; i++) stage_q[i] <= stage_q[i-1];
    end
  end

  assign irq_o = stage_q[DEPTH-1];
endmodule

// File: rtl/wb_commit_unit.sv
// Write-back commit unit: commits one instruction per accept, stalls on multi-cycle
// results and raises traps. Optional retire counter under `WB_RETIRE_CNT_EN`.
module wb_commit_unit
  import wb_commit_unit_pkg::*;
#(
  parameter int unsigned XLEN     = 32,
  parameter int unsigned REG_AW   = 5,
  parameter int unsigned NUM_MC   = 2,
  parameter int unsigned IRQ_SYNC = 2,
  parameter int unsigned CNT_W    = 64
) (
  input  logic               clk,
  input  logic               rst_b,
  wb_commit_unit_if.slave    pipe,
  input  logic [2:0]         irq_in,
  input  logic [2:0]         irq_enable,
  output logic               wb_rd_write,
  output logic [REG_AW-1:0]  wb_rd_addr,
  output logic [XLEN-1:0]    wb_rd_wdata,
  output logic               wb_trap,
  output logic [XLEN-1:0]    wb_trap_cause,
  output logic [XLEN-1:0]    wb_trap_epc,
  output logic               wb_retire,
  output logic [CNT_W-1:0]   wb_retire_cnt
);
  localparam int unsigned IRQ_BIT = mcause_irq_bit(XLEN);

  wb_state_e         state_q, state_d;
  logic [2:0]        irq_synced, irq_act;
  logic              irq_take;
  logic [3:0]        irq_code;
  logic              sel_ready;
  logic [XLEN-1:0]   mc_data, commit_data;

  logic              rd_write_q, rd_write_d;
  logic [REG_AW-1:0] rd_addr_q, rd_addr_d;
  logic [XLEN-1:0]   rd_wdata_q, rd_wdata_d;
  logic              trap_q, trap_d;
  logic [XLEN-1:0]   cause_q, cause_d;
  logic [XLEN-1:0]   epc_q, epc_d;
  logic              retire_q, retire_d;

  irq_sync #(.WIDTH(3), .DEPTH(IRQ_SYNC)) u_irq_sync (
    .clk   (clk),
    .rst_b (rst_b),
    .irq_i (irq_in),
    .irq_o (irq_synced)
  );

  // irq bit order is {meip, mtip, msip}; MEI > MSI > MTI
  always_comb begin
    irq_act  = irq_synced & irq_enable;
    irq_take = |irq_act;
    irq_code = IRQ_MTI;
    if (irq_act[0]) irq_code = IRQ_MSI;
    if (irq_act[2]) irq_code = IRQ_MEI;
  end

  always_comb begin
    mc_data = '0;
    for (int unsigned i = 0; i < NUM_MC; i++) begin
      if (pipe.wb_pipe_mc_sel[i]) mc_data = mc_data | pipe.mc_result[i*XLEN +: XLEN];
    end
    sel_ready   = |(pipe.wb_pipe_mc_sel & pipe.mc_result_valid);
    commit_data = (pipe.wb_pipe_mc_sel == '0) ? pipe.wb_pipe_rd_data : mc_data;
  end

  always_comb begin
    state_d            = state_q;
    pipe.wb_pipe_ready = 1'b0;
    pipe.wb_pipe_flush = 1'b0;
    pipe.mc_result_ack = '0;
    rd_write_d         = 1'b0;
    rd_addr_d          = '0;
    rd_wdata_d         = '0;
    trap_d             = 1'b0;
    cause_d            = '0;
    epc_d              = '0;
    retire_d           = 1'b0;
    case (state_q)
      WB_IDLE: begin
        pipe.wb_pipe_ready = 1'b1;
        if (pipe.wb_pipe_valid) begin
          if (irq_take || pipe.wb_pipe_exc_pending) begin
            pipe.wb_pipe_flush = 1'b1;
            trap_d             = 1'b1;
            epc_d              = pipe.wb_pipe_pc;
            state_d            = WB_TRAP;
            if (irq_take) begin
              cause_d[3:0]    = irq_code;
              cause_d[IRQ_BIT] = 1'b1;
            end else begin
              cause_d[3:0] = pipe.wb_pipe_exc_code;
            end
          end else if (pipe.wb_pipe_mret) begin
            pipe.wb_pipe_flush = 1'b1;
            retire_d           = 1'b1;
          end else if (pipe.wb_pipe_mc_sel == '0 || sel_ready) begin
            pipe.mc_result_ack = pipe.wb_pipe_mc_sel & pipe.mc_result_valid;
            retire_d           = 1'b1;
            rd_write_d         = pipe.wb_pipe_rd_write && (pipe.wb_pipe_rd_addr != '0);
          end else begin
            pipe.wb_pipe_ready = 1'b0;
            state_d            = WB_WAIT_MC;
          end
        end
      end
      WB_WAIT_MC: begin
        if (sel_ready) begin
          pipe.wb_pipe_ready = 1'b1;
          pipe.mc_result_ack = pipe.wb_pipe_mc_sel & pipe.mc_result_valid;
          retire_d           = 1'b1;
          rd_write_d         = pipe.wb_pipe_rd_write && (pipe.wb_pipe_rd_addr != '0);
          state_d            = WB_IDLE;
        end
      end
      WB_TRAP: begin
        pipe.wb_pipe_flush = 1'b1;
        state_d            = WB_IDLE;
      end
      default: state_d = WB_IDLE;
    endcase
    if (rd_write_d) begin
      rd_addr_d  = pipe.wb_pipe_rd_addr;
      rd_wdata_d = commit_data;
    end
  end

  always_ff @(posedge clk or negedge rst_b) begin
    if (!rst_b) begin
      state_q    <= WB_IDLE;
      rd_write_q <= 1'b0;
      rd_addr_q  <= '0;
      rd_wdata_q <= '0;
      trap_q     <= 1'b0;
      cause_q    <= '0;
      epc_q      <= '0;
      retire_q   <= 1'b0;
    end else begin
      state_q    <= state_d;
      rd_write_q <= rd_write_d;
      rd_addr_q  <= rd_addr_d;
      rd_wdata_q <= rd_wdata_d;
      trap_q     <= trap_d;
      cause_q    <= cause_d;
      epc_q      <= epc_d;
      retire_q   <= retire_d;
    end
  end

  assign wb_rd_write   = rd_write_q;
  assign wb_rd_addr    = rd_addr_q;
  assign wb_rd_wdata   = rd_wdata_q;
  assign wb_trap       = trap_q;
  assign wb_trap_cause = cause_q;
  assign wb_trap_epc   = epc_q;
  assign wb_retire     = retire_q;

`ifdef WB_RETIRE_CNT_EN
  logic [CNT_W-1:0] cnt_q, cnt_d;

  // counts on the same edge that raises wb_retire, so the two appear together
  assign cnt_d = retire_d ? cnt_q + 1'b1 : cnt_q;

  always_ff @(posedge clk or negedge rst_b) begin
    if (!rst_b) cnt_q <= '0;
    else        cnt_q <= cnt_d;
  end

  assign wb_retire_cnt = cnt_q;
`else
  assign wb_retire_cnt = '0;
`endif

`ifndef SYNTHESIS
  mc_sel_onehot_a: assert property (@(posedge clk) disable iff (!rst_b)
    pipe.wb_pipe_valid |-> $onehot0(pipe.wb_pipe_mc_sel));
`endif
endmodule

// File: tb/tb_wb_commit_unit.sv
// Scoreboard bench for wb_commit_unit: expected commits are queued at drive time
// and popped when the DUT raises wb_retire or wb_trap.
module tb_wb_commit_unit;
  localparam int unsigned XLEN = 32, REG_AW = 5, NUM_MC = 2, IRQ_SYNC = 2, CNT_W = 64;

  logic              clk = 1'b0;
  logic              rst_b;
  logic [2:0]        irq_in, irq_enable;
  logic              wb_rd_write, wb_trap, wb_retire;
  logic [REG_AW-1:0] wb_rd_addr;
  logic [XLEN-1:0]   wb_rd_wdata, wb_trap_cause, wb_trap_epc;
  logic [CNT_W-1:0]  wb_retire_cnt;

  wb_commit_unit_if #(.XLEN(XLEN), .REG_AW(REG_AW), .NUM_MC(NUM_MC)) pipe_if ();

  wb_commit_unit #(
    .XLEN(XLEN), .REG_AW(REG_AW), .NUM_MC(NUM_MC), .IRQ_SYNC(IRQ_SYNC), .CNT_W(CNT_W)
  ) dut (
    .clk(clk), .rst_b(rst_b), .pipe(pipe_if), .irq_in(irq_in), .irq_enable(irq_enable),
    .wb_rd_write(wb_rd_write), .wb_rd_addr(wb_rd_addr), .wb_rd_wdata(wb_rd_wdata),
    .wb_trap(wb_trap), .wb_trap_cause(wb_trap_cause), .wb_trap_epc(wb_trap_epc),
    .wb_retire(wb_retire), .wb_retire_cnt(wb_retire_cnt)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic        rd_write;
    logic [4:0]  rd_addr;
    logic [31:0] rd_wdata;
    logic        trap;
    logic [31:0] cause;
    logic [31:0] epc;
    logic        retire;
  } exp_t;

  exp_t sb_q[$];
  exp_t mon_e;
  int   n_tests = 0, n_fail = 0;
  int   ack_cnt, ack_ch0_cnt, stall_cnt, flush_cnt, retired_cnt;
  logic [1:0] last_ack;

  task automatic check_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_tests++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  function automatic exp_t mk(input logic rdw, input logic [4:0] rd, input logic [31:0] data,
                              input logic trap, input logic [31:0] cause, input logic [31:0] epc,
                              input logic retire);
    exp_t e;
    e.rd_write = rdw;  e.rd_addr = rd;  e.rd_wdata = data;
    e.trap = trap;     e.cause = cause; e.epc = epc; e.retire = retire;
    return e;
  endfunction

  always @(negedge clk) begin
    if (rst_b === 1'b1) begin
      if (pipe_if.mc_result_ack != 2'b00) begin ack_cnt++; last_ack = pipe_if.mc_result_ack; end
      if (pipe_if.mc_result_ack[0]) ack_ch0_cnt++;
      if (pipe_if.wb_pipe_valid && !pipe_if.wb_pipe_ready) stall_cnt++;
      if (pipe_if.wb_pipe_flush) flush_cnt++;
      if (wb_retire || wb_trap) begin
        if (sb_q.size() == 0) begin
          check_eq("sb_unexpected", 64'(1), 64'(0));
        end else begin
          mon_e = sb_q.pop_front();
          if (mon_e.retire) retired_cnt++;
          check_eq("retire", 64'(wb_retire), 64'(mon_e.retire));
          check_eq("trap", 64'(wb_trap), 64'(mon_e.trap));
          check_eq("rd_write", 64'(wb_rd_write), 64'(mon_e.rd_write));
          if (mon_e.rd_write) begin
            check_eq("rd_addr", 64'(wb_rd_addr), 64'(mon_e.rd_addr));
            check_eq("rd_wdata", 64'(wb_rd_wdata), 64'(mon_e.rd_wdata));
          end
          if (mon_e.trap) begin
            check_eq("trap_cause", 64'(wb_trap_cause), 64'(mon_e.cause));
            check_eq("trap_epc", 64'(wb_trap_epc), 64'(mon_e.epc));
          end
        end
      end else begin
        check_eq("idle_rd_write", 64'(wb_rd_write), 64'(0));
      end
    end
  end

  task automatic clear_pipe();
    pipe_if.wb_pipe_valid = 1'b0;       pipe_if.wb_pipe_pc = '0;
    pipe_if.wb_pipe_rd_write = 1'b0;    pipe_if.wb_pipe_rd_addr = '0;
    pipe_if.wb_pipe_rd_data = '0;       pipe_if.wb_pipe_mc_sel = '0;
    pipe_if.wb_pipe_exc_pending = 1'b0; pipe_if.wb_pipe_exc_code = '0;
    pipe_if.wb_pipe_mret = 1'b0;
  endtask

  task automatic clear_stats();
    ack_cnt = 0; ack_ch0_cnt = 0; stall_cnt = 0; flush_cnt = 0; last_ack = 2'b00;
  endtask

  task automatic send(input logic [31:0] pc, input logic rdw, input logic [4:0] rd,
                      input logic [31:0] data, input logic [1:0] sel, input logic exc,
                      input logic [3:0] code, input logic mret, input exp_t e);
    logic accepted;
    @(posedge clk); #1;
    pipe_if.wb_pipe_valid = 1'b1;       pipe_if.wb_pipe_pc = pc;
    pipe_if.wb_pipe_rd_write = rdw;     pipe_if.wb_pipe_rd_addr = rd;
    pipe_if.wb_pipe_rd_data = data;     pipe_if.wb_pipe_mc_sel = sel;
    pipe_if.wb_pipe_exc_pending = exc;  pipe_if.wb_pipe_exc_code = code;
    pipe_if.wb_pipe_mret = mret;
    sb_q.push_back(e);
    accepted = 1'b0;
    for (int i = 0; i < 50 && !accepted; i++) begin
      @(negedge clk);
      if (pipe_if.wb_pipe_ready) accepted = 1'b1;
    end
    check_eq("accept_timeout", 64'(accepted), 64'(1));
    @(posedge clk); #1;
    clear_pipe();
  endtask

  task automatic drain();
    for (int i = 0; i < 5 && sb_q.size() != 0; i++) @(negedge clk);
    check_eq("sb_drain", 64'(sb_q.size()), 64'(0));
    repeat (2) @(negedge clk);
  endtask

  task automatic mc_respond(input int unsigned ch, input logic [31:0] val, input int unsigned delay);
    logic got;
    repeat (delay) @(posedge clk);
    #1;
    pipe_if.mc_result[ch*XLEN +: XLEN] = val;
    pipe_if.mc_result_valid[ch] = 1'b1;
    got = 1'b0;
    for (int i = 0; i < 30 && !got; i++) begin
      @(negedge clk);
      if (pipe_if.mc_result_ack[ch]) got = 1'b1;
    end
    check_eq("mc_ack_timeout", 64'(got), 64'(1));
    @(posedge clk); #1;
    pipe_if.mc_result_valid[ch] = 1'b0;
  endtask

  task automatic irq_quiet();
    irq_in = 3'b000;
    repeat (IRQ_SYNC + 2) @(posedge clk);
  endtask

  initial begin
    rst_b = 1'b0; irq_in = 3'b000; irq_enable = 3'b000;
    clear_pipe();
    pipe_if.mc_result_valid = '0; pipe_if.mc_result = '0;
    clear_stats(); retired_cnt = 0;

    // reset state
    repeat (3) @(negedge clk);
    check_eq("rst_rd_write", 64'(wb_rd_write), 64'(0));
    check_eq("rst_trap", 64'(wb_trap), 64'(0));
    check_eq("rst_retire", 64'(wb_retire), 64'(0));
    check_eq("rst_cause", 64'(wb_trap_cause), 64'(0));
    @(posedge clk); #1 rst_b = 1'b1;
    @(negedge clk);
    check_eq("rst_ready", 64'(pipe_if.wb_pipe_ready), 64'(1));
    check_eq("rst_flush", 64'(pipe_if.wb_pipe_flush), 64'(0));

    // ALU writeback, rd=0 suppression, mret
    clear_stats();
    send(32'h40, 1'b1, 5'd5, 32'hDEADBEEF, 2'b00, 1'b0, 4'd0, 1'b0,
         mk(1'b1, 5'd5, 32'hDEADBEEF, 1'b0, 32'h0, 32'h0, 1'b1));
    send(32'h44, 1'b1, 5'd0, 32'h12345678, 2'b00, 1'b0, 4'd0, 1'b0,
         mk(1'b0, 5'd0, 32'h0, 1'b0, 32'h0, 32'h0, 1'b1));
    drain();
    check_eq("alu_stall", 64'(stall_cnt), 64'(0));
    check_eq("alu_flush", 64'(flush_cnt), 64'(0));
    clear_stats();
    send(32'h48, 1'b1, 5'd6, 32'h1, 2'b00, 1'b0, 4'd0, 1'b1,
         mk(1'b0, 5'd0, 32'h0, 1'b0, 32'h0, 32'h0, 1'b1));
    drain();
    check_eq("mret_flush", 64'(flush_cnt), 64'(1));

    // divider stall on channel 1 while channel 0 is valid but unselected
    clear_stats();
    #1;
    pipe_if.mc_result[31:0] = 32'h55; pipe_if.mc_result_valid[0] = 1'b1;
    fork
      send(32'h80, 1'b1, 5'd9, 32'hAAAA, 2'b10, 1'b0, 4'd0, 1'b0,
           mk(1'b1, 5'd9, 32'h7, 1'b0, 32'h0, 32'h0, 1'b1));
      mc_respond(1, 32'h7, 5);
    join
    drain();
    pipe_if.mc_result_valid[0] = 1'b0;
    check_eq("div_stall_cycles", 64'(stall_cnt), 64'(4));
    check_eq("div_ack_count", 64'(ack_cnt), 64'(1));
    check_eq("div_ack_value", 64'(last_ack), 64'(2'b10));
    check_eq("div_ch0_ack", 64'(ack_ch0_cnt), 64'(0));

    // exception: mc_sel is ignored, flush in accept and TRAP cycles
    clear_stats();
    send(32'h100, 1'b1, 5'd3, 32'h9, 2'b01, 1'b1, 4'd2, 1'b0,
         mk(1'b0, 5'd0, 32'h0, 1'b1, 32'h2, 32'h100, 1'b0));
    drain();
    check_eq("exc_flush", 64'(flush_cnt), 64'(2));
    check_eq("exc_stall", 64'(stall_cnt), 64'(0));

    // interrupts: MEI wins over MTI, and over a pending exception
    irq_enable = 3'b110; irq_in = 3'b111;
    repeat (IRQ_SYNC + 1) @(posedge clk);
    send(32'h200, 1'b1, 5'd3, 32'h1234, 2'b00, 1'b0, 4'd0, 1'b0,
         mk(1'b0, 5'd0, 32'h0, 1'b1, 32'h8000000B, 32'h200, 1'b0));
    send(32'h204, 1'b1, 5'd3, 32'h1234, 2'b00, 1'b1, 4'd5, 1'b0,
         mk(1'b0, 5'd0, 32'h0, 1'b1, 32'h8000000B, 32'h204, 1'b0));
    drain();
    irq_quiet();
    irq_enable = 3'b011; irq_in = 3'b011;
    repeat (IRQ_SYNC + 1) @(posedge clk);
    send(32'h208, 1'b0, 5'd0, 32'h0, 2'b00, 1'b0, 4'd0, 1'b0,
         mk(1'b0, 5'd0, 32'h0, 1'b1, 32'h80000003, 32'h208, 1'b0));
    drain();
    irq_quiet();

    // interrupt rising during WAIT_MC is deferred to the next instruction
    irq_enable = 3'b001;
    fork
      send(32'h300, 1'b1, 5'd7, 32'h0, 2'b01, 1'b0, 4'd0, 1'b0,
           mk(1'b1, 5'd7, 32'h12345678, 1'b0, 32'h0, 32'h0, 1'b1));
      begin
        repeat (3) @(posedge clk);
        #1 irq_in = 3'b001;
      end
      mc_respond(0, 32'h12345678, 7);
    join
    send(32'h304, 1'b1, 5'd8, 32'h5, 2'b00, 1'b0, 4'd0, 1'b0,
         mk(1'b0, 5'd0, 32'h0, 1'b1, 32'h80000003, 32'h304, 1'b0));
    drain();
    irq_quiet();
    irq_enable = 3'b000;

    // reset while waiting on a multi-cycle result
    @(posedge clk); #1;
    pipe_if.wb_pipe_valid = 1'b1; pipe_if.wb_pipe_mc_sel = 2'b10;
    pipe_if.wb_pipe_rd_write = 1'b1; pipe_if.wb_pipe_rd_addr = 5'd4; pipe_if.wb_pipe_pc = 32'h400;
    repeat (3) @(posedge clk);
    #1 rst_b = 1'b0;
    clear_pipe();
    @(negedge clk);
    check_eq("rstw_rd_write", 64'(wb_rd_write), 64'(0));
    check_eq("rstw_retire", 64'(wb_retire), 64'(0));
    check_eq("rstw_trap", 64'(wb_trap), 64'(0));
    check_eq("rstw_ack", 64'(pipe_if.mc_result_ack), 64'(0));
    retired_cnt = 0;
    @(posedge clk); #1 rst_b = 1'b1;
    pipe_if.mc_result[63:32] = 32'h99; pipe_if.mc_result_valid[1] = 1'b1;
    @(negedge clk);
    check_eq("rstw_ready", 64'(pipe_if.wb_pipe_ready), 64'(1));
    check_eq("rstw_no_ack", 64'(pipe_if.mc_result_ack), 64'(0));
    @(posedge clk); #1 pipe_if.mc_result_valid[1] = 1'b0;
    send(32'h500, 1'b1, 5'd12, 32'hCAFEF00D, 2'b00, 1'b0, 4'd0, 1'b0,
         mk(1'b1, 5'd12, 32'hCAFEF00D, 1'b0, 32'h0, 32'h0, 1'b1));
    drain();

`ifdef WB_RETIRE_CNT_EN
    check_eq("retire_cnt", wb_retire_cnt, 64'(retired_cnt));
`else
    check_eq("retire_cnt", wb_retire_cnt, 64'(0));
`endif

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: got 0x0 expected 0x1");
    $fatal(1, "timeout");
  end
endmodule
